control_unit: RTL and testbench

//  Hardwired Moore FSM that drives every control input of data_path and consumes its
//  IR_OUT, MOC and Cond. Sequences fetch, decode, data-processing, word/byte load/store
//  and branch(-with-link). One state per cycle; memory states wait on MOC with a timeout.

---
 rtl/control_unit.sv | 175 +++++++++++++++++
 tb/tb_control_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore control FSM for data_path: fetch, decode, data-processing,
// word/byte load/store and branch(-with-link), with a MOC timeout guard.
module control_unit #(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        MOC,
  input  logic        Cond,
  output logic        SE,
  output logic        FR_ld,
  output logic        RF_ld,
  output logic        IR_ld,
  output logic        MAR_ld,
  output logic        MDR_ld,
  output logic        R_W,
  output logic        MOV,
  output logic [1:0]  size,
  output logic        MA_1,
  output logic        MA_0,
  output logic        MB_1,
  output logic        MB_0,
  output logic        MC_2,
  output logic        MC_1,
  output logic        MC_0,
  output logic        MD,
  output logic        ME,
  output logic [4:0]  OP,
  output logic        fault,
  output logic [4:0]  state
);

  localparam logic [4:0] OP_ADD   = 5'b00100;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_MOVB  = 5'b01101;
  localparam logic [4:0] OP_PASSA = 5'b10000;
  localparam logic [4:0] OP_INC4  = 5'b10001;

  localparam int CW = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;

  typedef enum logic [4:0] {
    S_RESET = 5'd0,
    S_F1, S_F2, S_F3, S_F4, S_DEC,
    S_DP, S_LSA, S_LD1, S_LD2, S_ST1, S_ST2,
    S_BL, S_BR, S_FAULT
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic          mem_wait;
  logic          timeout;
  logic [1:0]    ma, mb;
  logic [2:0]    mc;
  logic [1:0]    ls_size;
  logic          unused_ir;

  assign unused_ir = ^{IR[31:28], IR[21], IR[19:0]};

  assign mem_wait = (cur == S_F3) || (cur == S_LD1) || (cur == S_ST2);
  assign timeout  = (MOC_TIMEOUT != 0) && (wait_cnt == CW'(MOC_TIMEOUT - 1));
  assign ls_size  = IR[22] ? 2'b00 : 2'b10;

  // The wait counter only runs while a memory state is held; every exit clears it,
  // so each memory state is entered with a count of zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cur      <= S_RESET;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (mem_wait && !MOC && (nxt == cur))
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    nxt    = cur;
    SE     = 1'b0;
    FR_ld  = 1'b0;
    RF_ld  = 1'b0;
    IR_ld  = 1'b0;
    MAR_ld = 1'b0;
    MDR_ld = 1'b0;
    R_W    = 1'b0;
    MOV    = 1'b0;
    size   = 2'b00;
    ma     = 2'b00;
    mb     = 2'b00;
    mc     = 3'b000;
    MD     = 1'b0;
    ME     = 1'b0;
    OP     = 5'b00000;
    fault  = 1'b0;
    case (cur)
      S_RESET: nxt = S_F1;
      S_F1: begin
        ma = 2'b10; mb = 2'b11; MD = 1'b1; OP = OP_PASSA; MAR_ld = 1'b1;
        nxt = S_F2;
      end
      S_F2: begin
        ma = 2'b10; MD = 1'b1; OP = OP_INC4; mc = 3'b001; RF_ld = 1'b1;
        nxt = S_F3;
      end
      S_F3: begin
        MOV = 1'b1; R_W = 1'b1; size = 2'b10;
        if (MOC)          nxt = S_F4;
        else if (timeout) nxt = S_FAULT;
      end
      S_F4: begin
        MOV = 1'b1; R_W = 1'b1; size = 2'b10; IR_ld = 1'b1;
        nxt = S_DEC;
      end
      S_DEC: begin
        if (!Cond)                   nxt = S_F1;
        else if (IR[27:26] == 2'b00)  nxt = S_DP;
        else if (IR[27:25] == 3'b010) nxt = S_LSA;
        else if (IR[27:25] == 3'b101) nxt = IR[24] ? S_BL : S_BR;
        else                         nxt = S_F1;
      end
      // Test/compare opcodes (IR[24:23]=10) only update flags.
      S_DP: begin
        mb = 2'b01; RF_ld = (IR[24:23] != 2'b10); FR_ld = IR[20];
        nxt = S_F1;
      end
      S_LSA: begin
        mb = 2'b01; MD = 1'b1; OP = IR[23] ? OP_ADD : OP_SUB; MAR_ld = 1'b1;
        nxt = IR[20] ? S_LD1 : S_ST1;
      end
      S_LD1: begin
        MOV = 1'b1; R_W = 1'b1; size = ls_size; MDR_ld = 1'b1;
        if (MOC)          nxt = S_LD2;
        else if (timeout) nxt = S_FAULT;
      end
      S_LD2: begin
        mb = 2'b10; MD = 1'b1; OP = OP_MOVB; RF_ld = 1'b1;
        nxt = S_F1;
      end
      S_ST1: begin
        ma = 2'b01; mb = 2'b11; MD = 1'b1; OP = OP_PASSA; ME = 1'b1; MDR_ld = 1'b1;
        nxt = S_ST2;
      end
      S_ST2: begin
        MOV = 1'b1; size = ls_size;
        if (MOC)          nxt = S_F1;
        else if (timeout) nxt = S_FAULT;
      end
      S_BL: begin
        ma = 2'b10; mb = 2'b11; MD = 1'b1; OP = OP_PASSA; mc = 3'b100; RF_ld = 1'b1;
        nxt = S_BR;
      end
      S_BR: begin
        ma = 2'b10; mb = 2'b01; MD = 1'b1; OP = OP_ADD; mc = 3'b001; RF_ld = 1'b1;
        nxt = S_F1;
      end
      S_FAULT: begin
        fault = 1'b1;
        nxt   = S_FAULT;
      end
      default: nxt = S_RESET;
    endcase
  end

  assign MA_1  = ma[1];
  assign MA_0  = ma[0];
  assign MB_1  = mb[1];
  assign MB_0  = mb[0];
  assign MC_2  = mc[2];
  assign MC_1  = mc[1];
  assign MC_0  = mc[0];
  assign state = cur;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: builds an expected per-cycle phase trace
// for each instruction and checks every cycle's control word against it.
module tb_control_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR = '0;
  logic        MOC = 1'b0;
  logic        Cond = 1'b0;
  logic        SE, FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV;
  logic [1:0]  size;
  logic        MA_1, MA_0, MB_1, MB_0, MC_2, MC_1, MC_0, MD, ME;
  logic [4:0]  OP;
  logic        fault;
  logic [4:0]  state;

  control_unit #(.MOC_TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .IR(IR), .MOC(MOC), .Cond(Cond),
    .SE(SE), .FR_ld(FR_ld), .RF_ld(RF_ld), .IR_ld(IR_ld), .MAR_ld(MAR_ld),
    .MDR_ld(MDR_ld), .R_W(R_W), .MOV(MOV), .size(size),
    .MA_1(MA_1), .MA_0(MA_0), .MB_1(MB_1), .MB_0(MB_0),
    .MC_2(MC_2), .MC_1(MC_1), .MC_0(MC_0), .MD(MD), .ME(ME),
    .OP(OP), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef enum {P_RESET, P_F1, P_F2, P_F3, P_F4, P_DEC, P_DP, P_LSA,
                P_LD1, P_LD2, P_ST1, P_ST2, P_BL, P_BR, P_FAULT} phase_t;

  typedef struct {
    phase_t      ph;
    logic [31:0] ir;
    logic        cond;
    logic        moc;
    logic [24:0] pin_mask;
    logic [24:0] pin_val;
  } entry_t;

  // Control word layout: SE FR RF IR MAR MDR RW MOV size[2] MA[2] MB[2] MC[3] MD ME OP[5] fault
  localparam logic [24:0] M_FR  = 25'd1 << 23;
  localparam logic [24:0] M_RF  = 25'd1 << 22;
  localparam logic [24:0] M_IRL = 25'd1 << 21;
  localparam logic [24:0] M_MAR = 25'd1 << 20;
  localparam logic [24:0] M_RW  = 25'd1 << 18;
  localparam logic [24:0] M_SZ  = 25'd3 << 15;
  localparam logic [24:0] M_MB  = 25'd3 << 11;
  localparam logic [24:0] M_MC  = 25'd7 << 8;
  localparam logic [24:0] M_MD  = 25'd1 << 7;
  localparam logic [24:0] M_ME  = 25'd1 << 6;
  localparam logic [24:0] M_OP  = 25'd31 << 1;
  localparam logic [24:0] M_FLT = 25'd1;

  entry_t      trace[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [24:0] act;

  assign act = {SE, FR_ld, RF_ld, IR_ld, MAR_ld, MDR_ld, R_W, MOV, size,
                MA_1, MA_0, MB_1, MB_0, MC_2, MC_1, MC_0, MD, ME, OP, fault};

  function automatic logic [24:0] model(phase_t p, logic [31:0] ir);
    logic fr, rf, irl, mar, mdr, rw, mov, md, me, flt;
    logic [1:0] sz, ma, mb;
    logic [2:0] mc;
    logic [4:0] op;
    {fr, rf, irl, mar, mdr, rw, mov, md, me, flt} = '0;
    sz = 2'b00; ma = 2'b00; mb = 2'b00; mc = 3'b000; op = 5'b00000;
    case (p)
      P_F1:    begin ma = 2'b10; mb = 2'b11; md = 1; op = 5'b10000; mar = 1; end
      P_F2:    begin ma = 2'b10; md = 1; op = 5'b10001; mc = 3'b001; rf = 1; end
      P_F3:    begin mov = 1; rw = 1; sz = 2'b10; end
      P_F4:    begin mov = 1; rw = 1; sz = 2'b10; irl = 1; end
      P_DP:    begin mb = 2'b01; rf = !(ir[24] && !ir[23]); fr = ir[20]; end
      P_LSA:   begin mb = 2'b01; md = 1; op = ir[23] ? 5'b00100 : 5'b00010; mar = 1; end
      P_LD1:   begin mov = 1; rw = 1; sz = ir[22] ? 2'b00 : 2'b10; mdr = 1; end
      P_LD2:   begin mb = 2'b10; md = 1; op = 5'b01101; rf = 1; end
      P_ST1:   begin ma = 2'b01; mb = 2'b11; md = 1; op = 5'b10000; me = 1; mdr = 1; end
      P_ST2:   begin mov = 1; sz = ir[22] ? 2'b00 : 2'b10; end
      P_BL:    begin ma = 2'b10; mb = 2'b11; md = 1; op = 5'b10000; mc = 3'b100; rf = 1; end
      P_BR:    begin ma = 2'b10; mb = 2'b01; md = 1; op = 5'b00100; mc = 3'b001; rf = 1; end
      P_FAULT: flt = 1;
      default: ;
    endcase
    return {1'b0, fr, rf, irl, mar, mdr, rw, mov, sz, ma, mb, mc, md, me, op, flt};
  endfunction

  function automatic void add(phase_t p, logic [31:0] ir, logic c, logic m);
    entry_t e;
    e.ph = p; e.ir = ir; e.cond = c; e.moc = m; e.pin_mask = '0; e.pin_val = '0;
    trace.push_back(e);
  endfunction

  // A memory phase held w cycles with MOC low, then MOC on the next; a hold that
  // reaches the timeout turns into a run of FAULT cycles with MOC toggling freely.
  function automatic bit mem(phase_t p, int w, logic [31:0] ir, logic c);
    if (w >= TO) begin
      for (int i = 0; i < TO; i++) add(p, ir, c, 1'b0);
      for (int i = 0; i < 4; i++) add(P_FAULT, ir, c, 1'($urandom_range(0, 1)));
      return 1'b1;
    end
    for (int i = 0; i < w; i++) add(p, ir, c, 1'b0);
    add(p, ir, c, 1'b1);
    return 1'b0;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void build_instr(logic [31:0] ir, logic c, int fw, int mw);
    add(P_F1, ir, c, rnd());
    add(P_F2, ir, c, rnd());
    void'(mem(P_F3, fw, ir, c));
    add(P_F4, ir, c, rnd());
    add(P_DEC, ir, c, rnd());
    if (!c) return;
    if (ir[27:26] == 2'b00) add(P_DP, ir, c, rnd());
    else if (ir[27:25] == 3'b010) begin
      add(P_LSA, ir, c, rnd());
      if (ir[20]) begin
        if (mem(P_LD1, mw, ir, c)) return;
        add(P_LD2, ir, c, rnd());
      end else begin
        add(P_ST1, ir, c, rnd());
        void'(mem(P_ST2, mw, ir, c));
      end
    end else if (ir[27:25] == 3'b101) begin
      if (ir[24]) add(P_BL, ir, c, rnd());
      add(P_BR, ir, c, rnd());
    end
  endfunction

  function automatic void pin_last(phase_t p, logic [24:0] mask, logic [24:0] val);
    for (int i = trace.size() - 1; i >= 0; i--) begin
      if (trace[i].ph == p) begin
        trace[i].pin_mask = mask;
        trace[i].pin_val  = val;
        return;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [24:0] got, input logic [24:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    entry_t e;
    string  nm;
    while (trace.size() > 0) begin
      e = trace.pop_front();
      IR = e.ir;
      Cond = e.cond;
      #1;
      nm = e.ph.name();
      checkOutput(nm, act, model(e.ph, e.ir));
      if (e.ph == P_RESET) checkOutput("reset_state", {20'd0, state}, 25'd0);
      if (e.pin_mask != '0) checkOutput({nm, "_pin"}, act & e.pin_mask, e.pin_val);
      MOC = e.moc;
      @(negedge clk);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    clr = 1'b1;
    MOC = 1'b0;
    #1;
    checkOutput("clr_outputs", act, 25'd0);
    checkOutput("clr_state", {20'd0, state}, 25'd0);
    @(negedge clk);
    #1;
    checkOutput("clr_hold", act, 25'd0);
    clr = 1'b0;
  endtask

  initial begin
    // Reset, then interrupt a fetch while it waits on MOC.
    doReset();
    add(P_RESET, 32'h0, 1'b0, 1'b0);
    add(P_F1, 32'h0, 1'b0, 1'b0);
    add(P_F2, 32'h0, 1'b0, 1'b0);
    add(P_F3, 32'h0, 1'b0, 1'b0);
    add(P_F3, 32'h0, 1'b0, 1'b0);
    applyStimulus();
    #2 clr = 1'b1;
    #1;
    checkOutput("clr_mid_f3", act, 25'd0);
    checkOutput("clr_mid_f3_state", {20'd0, state}, 25'd0);

    // Instruction stream ending in a MOC timeout.
    doReset();
    add(P_RESET, 32'h0, 1'b0, 1'b0);
    build_instr(32'hE0812003, 1'b1, 2, 0);
    pin_last(P_F2, M_RF | M_MC | M_OP, M_RF | (25'd1 << 8) | (25'd17 << 1));
    pin_last(P_F4, M_IRL, M_IRL);
    pin_last(P_DP, M_RF | M_FR | M_MD, M_RF);
    build_instr(32'hE1510002, 1'b1, 0, 0);
    pin_last(P_DP, M_RF | M_FR, M_FR);
    build_instr(32'hE0812003, 1'b0, 1, 0);
    build_instr(32'hE1510002, 1'b0, 0, 0);
    build_instr(32'hE5912004, 1'b1, 1, 1);
    pin_last(P_LSA, M_OP | M_MAR, (25'd4 << 1) | M_MAR);
    pin_last(P_LD1, M_SZ, 25'd2 << 15);
    pin_last(P_LD2, M_MB | M_MC | M_RF, (25'd2 << 11) | M_RF);
    build_instr(32'hE5412004, 1'b1, 0, 2);
    pin_last(P_LSA, M_OP, 25'd2 << 1);
    pin_last(P_ST1, M_ME, M_ME);
    pin_last(P_ST2, M_RW | M_SZ, 25'd0);
    build_instr(32'hEB000002, 1'b1, 0, 0);
    pin_last(P_BL, M_MC | M_RF, (25'd4 << 8) | M_RF);
    pin_last(P_BR, M_OP | M_MC, (25'd4 << 1) | (25'd1 << 8));
    build_instr(32'hEA000002, 1'b1, 0, 0);
    build_instr(32'hEE000000, 1'b1, 0, 0);
    build_instr(32'hE5912004, 1'b1, 0, TO - 1);
    build_instr(32'hE5D12004, 1'b1, 0, TO);
    pin_last(P_FAULT, M_FLT, M_FLT);
    applyStimulus();

    // Recovery from FAULT only through clr.
    doReset();
    add(P_RESET, 32'h0, 1'b0, 1'b0);
    build_instr(32'hE0812003, 1'b1, 0, 0);
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
